// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: accumulates gated synaptic currents, leaks once
// per timestep tick, and fires and enters a refractory period when the membrane crosses threshold.
module lif_neuron #(
  parameter int N_SYN      = 3,
  parameter int WW         = 16,
  parameter int VW         = 24,
  parameter int THRESH     = 1000,
  parameter int V_RESET    = 0,
  parameter int LEAK_SHIFT = 4,
  parameter int REFRAC     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_SYN-1:0][WW-1:0]   syn_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       tick,
  output logic                       spike_out,
  output logic signed [VW-1:0]       v_mem,
  output logic                       refractory,
  output logic [15:0]                spike_count
);

  typedef enum logic {INTEGRATE, REFRACT} state_t;

  // Sum width holds every input plus the membrane without overflow before clamping.
  localparam int SW = ((VW > WW) ? VW : WW) + $clog2(N_SYN + 1) + 1;
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  localparam logic signed [SW-1:0] VMAX     = {{(SW-VW+1){1'b0}}, {(VW-1){1'b1}}};
  localparam logic signed [SW-1:0] VMIN     = {{(SW-VW+1){1'b1}}, {(VW-1){1'b0}}};
  localparam logic signed [VW-1:0] THRESH_V = VW'(THRESH);
  localparam logic signed [VW-1:0] VRST_V   = VW'(V_RESET);

  state_t                state_q, state_d;
  logic [RW-1:0]         cnt_q, cnt_d;
  logic signed [VW-1:0]  v_q, v_d;
  logic                  spike_q, spike_d;
  logic [15:0]           count_q, count_d;
  logic                  ready_q;

  logic signed [SW-1:0]  term, acc, vext, sum;
  logic signed [VW-1:0]  sat, va, leaked;
  logic                  accept;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc = '0;
    term = '0;
    for (int i = 0; i < N_SYN; i++) begin
      term = {{(SW-WW){syn_in[i][WW-1]}}, syn_in[i]};
      acc  = acc + term;
    end
    vext = {{(SW-VW){v_q[VW-1]}}, v_q};
    sum  = acc + vext;
    if (sum > VMAX)      sat = VMAX[VW-1:0];
    else if (sum < VMIN) sat = VMIN[VW-1:0];
    else                 sat = sum[VW-1:0];

    accept = in_valid && ready_q;
    // Input is applied before the leak when accept and tick coincide.
    va     = (accept && state_q == INTEGRATE) ? sat : v_q;
    leaked = va - (va >>> LEAK_SHIFT);

    state_d = state_q;
    cnt_d   = cnt_q;
    v_d     = v_q;
    spike_d = 1'b0;
    count_d = count_q;

    case (state_q)
      INTEGRATE: begin
        if (tick) begin
          if (leaked >= THRESH_V) begin
            v_d     = VRST_V;
            spike_d = 1'b1;
            count_d = count_q + 16'd1;
            if (REFRAC != 0) begin
              state_d = REFRACT;
              cnt_d   = RW'(REFRAC);
            end
          end else begin
            v_d = leaked;
          end
        end else begin
          v_d = va;
        end
      end
      REFRACT: begin
        // Accepted inputs are dropped here; only ticks advance the counter.
        if (tick) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == RW'(1)) state_d = INTEGRATE;
        end
      end
      default: state_d = INTEGRATE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INTEGRATE;
      cnt_q   <= '0;
      v_q     <= '0;
      spike_q <= 1'b0;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      spike_q <= spike_d;
      count_q <= count_d;
      ready_q <= 1'b1;
    end
  end

  assign in_ready    = ready_q;
  assign spike_out   = spike_q;
  assign v_mem       = v_q;
  assign refractory  = (state_q == REFRACT);
  assign spike_count = count_q;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: an integer reference model pushes expected outputs
// into a scoreboard queue at drive time; entries are popped and checked after each edge.
module tb_lif_neuron;

  localparam int WW = 16;
  localparam int VW = 24;
  localparam longint VMAXI = 64'sd8388607;
  localparam longint VMINI = -64'sd8388608;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [2:0][WW-1:0]   syn_in = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 tick = 1'b0;
  logic                 spike_out;
  logic signed [VW-1:0] v_mem;
  logic                 refractory;
  logic [15:0]          spike_count;

  lif_neuron dut (
    .clk(clk), .rst_n(rst_n), .syn_in(syn_in), .in_valid(in_valid), .in_ready(in_ready),
    .tick(tick), .spike_out(spike_out), .v_mem(v_mem), .refractory(refractory),
    .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string                tag;
    logic signed [VW-1:0] v;
    logic                 spk;
    logic                 refr;
    logic [15:0]          cnt;
    logic                 rdy;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state (plain integers).
  longint mv = 0;
  bit     mref = 0;
  int     mrc = 0;
  int     mcount = 0;
  bit     mspk = 0;
  bit     mrdy = 0;

  function automatic longint floor_div16(input longint x);
    if (x >= 0) return x / 16;
    return -((-x + 15) / 16);
  endfunction

  task automatic cmp(input string tag, input longint obs, input longint expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step(input int a, input int b, input int c, input bit valid,
                      input bit tk, input bit rst, input string tag);
    longint va, lk;
    exp_t e, g;
    @(negedge clk);
    syn_in   = {WW'(c), WW'(b), WW'(a)};
    in_valid = valid;
    tick     = tk;
    rst_n    = !rst;
    if (rst) begin
      mv = 0; mref = 0; mrc = 0; mcount = 0; mspk = 0; mrdy = 0;
    end else begin
      mspk = 0;
      if (!mref) begin
        va = mv;
        if (valid && mrdy) begin
          va = mv + a + b + c;
          if (va > VMAXI) va = VMAXI;
          if (va < VMINI) va = VMINI;
        end
        if (tk) begin
          lk = va - floor_div16(va);
          if (lk >= 1000) begin
            mv = 0; mspk = 1; mcount = (mcount + 1) % 65536; mref = 1; mrc = 2;
          end else begin
            mv = lk;
          end
        end else begin
          mv = va;
        end
      end else if (tk) begin
        mrc--;
        if (mrc == 0) mref = 0;
      end
      mrdy = 1;
    end
    e.tag = tag; e.v = mv[VW-1:0]; e.spk = mspk; e.refr = mref;
    e.cnt = mcount[15:0]; e.rdy = mrdy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    cmp({g.tag, "_v"},    longint'(v_mem),       longint'(g.v));
    cmp({g.tag, "_spk"},  longint'(spike_out),   longint'(g.spk));
    cmp({g.tag, "_refr"}, longint'(refractory),  longint'(g.refr));
    cmp({g.tag, "_cnt"},  longint'(spike_count), longint'(g.cnt));
    cmp({g.tag, "_rdy"},  longint'(in_ready),    longint'(g.rdy));
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 1'b0, 1'b0, 1'b1, "reset");
    idle("post_reset");
  endtask

  initial begin
    // Reset state, including reset overriding simultaneous input and tick.
    step(300, 300, 300, 1'b1, 1'b1, 1'b1, "reset_ovr");
    cmp("reset_rdy_low", longint'(in_ready), 0);
    idle("first_idle");

    // Integrate then leak.
    step(300, 300, 300, 1'b1, 1'b0, 1'b0, "acc900");
    cmp("const_900", longint'(v_mem), 900);
    step(0, 0, 0, 1'b0, 1'b1, 1'b0, "leak844");
    cmp("const_844", longint'(v_mem), 844);

    // Same-cycle accept and tick crosses threshold: spike one cycle after tick edge.
    step(300, 300, 300, 1'b1, 1'b1, 1'b0, "fire1");
    cmp("const_fire_spk", longint'(spike_out), 1);
    cmp("const_fire_cnt", longint'(spike_count), 1);
    idle("spk_drop");
    cmp("const_spk_pulse", longint'(spike_out), 0);

    // Refractory discards input; two ticks release it.
    step(500, 500, 500, 1'b1, 1'b0, 1'b0, "refr_drop");
    cmp("const_refr_v0", longint'(v_mem), 0);
    step(0, 0, 0, 1'b0, 1'b1, 1'b0, "refr_t1");
    step(0, 0, 0, 1'b0, 1'b1, 1'b0, "refr_t2");
    cmp("const_refr_exit", longint'(refractory), 0);

    // Positive saturation without wrap.
    for (int i = 0; i < 90; i++) step(32767, 32767, 32767, 1'b1, 1'b0, 1'b0, "sat_pos");
    cmp("const_sat_max", longint'(v_mem), 8388607);

    // Negative saturation.
    do_reset();
    for (int i = 0; i < 90; i++) step(-32768, -32768, -32768, 1'b1, 1'b0, 1'b0, "sat_neg");
    cmp("const_sat_min", longint'(v_mem), -8388608);

    // Negative leak: -1000 >>> 4 = -63, so v becomes -1000 + 63 = -937.
    do_reset();
    step(-1000, 0, 0, 1'b1, 1'b0, 1'b0, "neg_acc");
    cmp("const_neg1000", longint'(v_mem), -1000);
    step(0, 0, 0, 1'b0, 1'b1, 1'b0, "neg_leak");
    cmp("const_neg_leak", longint'(v_mem), -937);

    // Threshold boundary: 1065 leaks to 999 (no fire), 1066 leaks to exactly 1000 (fire).
    do_reset();
    step(1065, 0, 0, 1'b1, 1'b1, 1'b0, "thr_below");
    cmp("const_thr_below", longint'(v_mem), 999);
    do_reset();
    step(1066, 0, 0, 1'b1, 1'b1, 1'b0, "thr_equal");
    cmp("const_thr_equal", longint'(spike_out), 1);

    // Build spike_count to 5 ending in REFRACT, then reset mid-refractory.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(400, 400, 400, 1'b1, 1'b1, 1'b0, "multi_fire");
      if (k < 4) begin
        step(0, 0, 0, 1'b0, 1'b1, 1'b0, "multi_t1");
        step(0, 0, 0, 1'b0, 1'b1, 1'b0, "multi_t2");
      end
    end
    cmp("const_cnt5", longint'(spike_count), 5);
    step(0, 0, 0, 1'b0, 1'b1, 1'b0, "mid_refr");
    step(300, 300, 300, 1'b1, 1'b1, 1'b1, "rst_in_refr");
    cmp("const_rst_cnt", longint'(spike_count), 0);
    cmp("const_rst_refr", longint'(refractory), 0);
    idle("rst_release");
    step(300, 300, 300, 1'b1, 1'b0, 1'b0, "post_rst_acc");
    cmp("const_post_rst", longint'(v_mem), 900);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
